// File: rtl/vga_pkg.sv
// Shared 640x480 timing defaults, pipeline flag bundle and 3-3-2 colour expansion.
package vga_pkg;

   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned H_FP_DEF     = 16;
   localparam int unsigned H_SYNC_DEF   = 96;
   localparam int unsigned H_BP_DEF     = 48;
   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned V_FP_DEF     = 10;
   localparam int unsigned V_SYNC_DEF   = 2;
   localparam int unsigned V_BP_DEF     = 33;

   localparam int unsigned CNT_W = 10;
   localparam int unsigned WIN_W = 512;

   typedef struct packed {
      logic active;
      logic window;
      logic hsync;
      logic vsync;
   } scan_flags_t;

   localparam scan_flags_t FLAGS_IDLE = '{active: 1'b0, window: 1'b0, hsync: 1'b1, vsync: 1'b1};

   typedef struct packed {
      logic [7:0] red;
      logic [7:0] green;
      logic [7:0] blue;
   } rgb_t;

   function automatic rgb_t expand_332(input logic [7:0] c);
      rgb_t o;
      o.red   = {c[7:5], c[7:5], c[7:6]};
      o.green = {c[4:2], c[4:2], c[4:3]};
      o.blue  = {4{c[1:0]}};
      return o;
   endfunction

endpackage

// File: rtl/vga_counter.sv
// Horizontal/vertical scan counters; run marks the first clock after reset release
// so that pixel (0,0) is presented for exactly one clock.
module vga_counter
   import vga_pkg::*;
#(
   parameter int unsigned H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF,
   parameter int unsigned V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF
) (
   input  logic             clk_vga,
   input  logic             reset_n,
   output logic             run,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount
);

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

   always_ff @(posedge clk_vga or negedge reset_n) begin
      if (!reset_n) begin
         run    <= 1'b0;
         hcount <= '0;
         vcount <= '0;
      end else begin
         run <= 1'b1;
         if (run) begin
            if (hcount == H_LAST) begin
               hcount <= '0;
               vcount <= (vcount == V_LAST) ? '0 : vcount + CNT_W'(1);
            end else begin
               hcount <= hcount + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/vga_scan_gen.sv
// VGA scan generator: 2x-scaled framebuffer window inside a bordered active area,
// with a 3-clock flag pipeline aligned to the 2-clock framebuffer read latency.
module vga_scan_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned H_FP     = H_FP_DEF,
   parameter int unsigned H_SYNC   = H_SYNC_DEF,
   parameter int unsigned H_BP     = H_BP_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned V_FP     = V_FP_DEF,
   parameter int unsigned V_SYNC   = V_SYNC_DEF,
   parameter int unsigned V_BP     = V_BP_DEF,
   parameter int unsigned WIN_X0   = 64,
   parameter logic [7:0]  BORDER   = 8'h00
) (
   input  logic        clk_vga,
   input  logic        reset_n,
   output logic        fb_rd,
   output logic [15:0] fb_addr,
   input  logic [7:0]  fb_data,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue,
   output logic        hsync,
   output logic        vsync,
   output logic        blank,
   output logic        frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CNT_W-1:0] WIN_BEG = CNT_W'(WIN_X0);
   localparam logic [CNT_W-1:0] WIN_END = CNT_W'(WIN_X0 + WIN_W);

   logic             run;
   logic [CNT_W-1:0] hcount;
   logic [CNT_W-1:0] vcount;
   logic [CNT_W-1:0] win_x;
   logic [7:0]       game_x;
   logic [7:0]       game_y;
   logic [15:0]      addr_d;
   logic [15:0]      addr_q;
   scan_flags_t      s0;
   scan_flags_t      s1_q;
   scan_flags_t      s2_q;
   rgb_t             pix;

   vga_counter #(
      .H_TOTAL(H_TOTAL),
      .V_TOTAL(V_TOTAL)
   ) u_counter (
      .clk_vga(clk_vga),
      .reset_n(reset_n),
      .run    (run),
      .hcount (hcount),
      .vcount (vcount)
   );

   // Stage-0 flags are forced idle until the counter is running.
   always_comb begin
      s0.active = run && (hcount < H_ACT_C) && (vcount < V_ACT_C);
      s0.window = s0.active && (hcount >= WIN_BEG) && (hcount < WIN_END);
      s0.hsync  = !(run && (hcount >= HS_BEG) && (hcount < HS_END));
      s0.vsync  = !(run && (vcount >= VS_BEG) && (vcount < VS_END));
   end

   assign win_x       = hcount - WIN_BEG;
   assign game_x      = 8'(win_x >> 1);
   assign game_y      = 8'(vcount >> 1);
   assign addr_d      = {game_y, game_x};
   assign fb_rd       = s0.window;
   assign fb_addr     = s0.window ? addr_d : addr_q;
   assign frame_start = run && (hcount == '0) && (vcount == '0);

   always_ff @(posedge clk_vga or negedge reset_n) begin
      if (!reset_n) begin
         s1_q   <= FLAGS_IDLE;
         s2_q   <= FLAGS_IDLE;
         addr_q <= '0;
      end else begin
         s1_q <= s0;
         s2_q <= s1_q;
         if (s0.window) begin
            addr_q <= addr_d;
         end
      end
   end

   // fb_data now carries the read issued two clocks ago, matching s2_q.
   always_comb begin
      if (!s2_q.active) begin
         pix = '0;
      end else if (s2_q.window) begin
         pix = expand_332(fb_data);
      end else begin
         pix = expand_332(BORDER);
      end
   end

   always_ff @(posedge clk_vga or negedge reset_n) begin
      if (!reset_n) begin
         red   <= '0;
         green <= '0;
         blue  <= '0;
         hsync <= 1'b1;
         vsync <= 1'b1;
         blank <= 1'b1;
      end else begin
         red   <= pix.red;
         green <= pix.green;
         blue  <= pix.blue;
         hsync <= s2_q.hsync;
         vsync <= s2_q.vsync;
         blank <= !s2_q.active;
      end
   end

endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench for vga_scan_gen; vertical timing shortened (15 lines/frame) to keep the run short.
module tb_vga_scan_gen;

   localparam int unsigned HT = 800;

   logic        clk_vga = 1'b0;
   logic        reset_n = 1'b0;
   logic        fb_rd;
   logic [15:0] fb_addr;
   logic [7:0]  fb_data;
   logic [7:0]  red;
   logic [7:0]  green;
   logic [7:0]  blue;
   logic        hsync;
   logic        vsync;
   logic        blank;
   logic        frame_start;

   int checks = 0;
   int errors = 0;
   int edge_cnt;

   logic [7:0] mem_d1;
   logic [7:0] mem_d2;

   vga_scan_gen #(
      .V_ACTIVE(8),
      .V_FP    (2),
      .V_SYNC  (2),
      .V_BP    (3),
      .BORDER  (8'hE0)
   ) dut (
      .clk_vga    (clk_vga),
      .reset_n    (reset_n),
      .fb_rd      (fb_rd),
      .fb_addr    (fb_addr),
      .fb_data    (fb_data),
      .red        (red),
      .green      (green),
      .blue       (blue),
      .hsync      (hsync),
      .vsync      (vsync),
      .blank      (blank),
      .frame_start(frame_start)
   );

   always #5 clk_vga = ~clk_vga;

   // Framebuffer model: data = addr[7:0], valid two clocks after the read.
   always @(posedge clk_vga) begin
      mem_d1 <= fb_addr[7:0];
      mem_d2 <= mem_d1;
   end
   assign fb_data = mem_d2;

   // Clock edges since reset release; edge n shows stage-0 pixel index n-1.
   always @(posedge clk_vga or negedge reset_n) begin
      if (!reset_n) edge_cnt <= 0;
      else          edge_cnt <= edge_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic at(input int n);
      int guard = 0;
      while (edge_cnt < n && guard < 50000) begin
         @(posedge clk_vga);
         #1;
         guard++;
      end
      if (edge_cnt != n) begin
         errors++;
         $error("FAIL seq: edge %0d expected %0d", edge_cnt, n);
      end
   endtask

   // Edge at which clock n of scan line 'line' is sampled (n = 0 is stage-0 hcount 0).
   function automatic int ln(input int line, input int n);
      return line * HT + 1 + n;
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      repeat (3) @(posedge clk_vga);
      #1;
      chk("rst_fb_rd", fb_rd, 1'b0);
      chk("rst_fb_addr", fb_addr, 16'h0000);
      chk("rst_rgb", {red, green, blue}, 24'h000000);
      chk("rst_hsync", hsync, 1'b1);
      chk("rst_vsync", vsync, 1'b1);
      chk("rst_blank", blank, 1'b1);
      chk("rst_fs", frame_start, 1'b0);

      @(negedge clk_vga);
      reset_n = 1'b1;
      #1;
      chk("fs_pre", frame_start, 1'b0);
      at(1);  chk("fs_first", frame_start, 1'b1);
      at(2);  chk("fs_after", frame_start, 1'b0);

      at(ln(0, 3));   chk("border_c0", {red, green, blue}, 24'hFF0000);
                      chk("blank_c0", blank, 1'b0);
      at(ln(0, 63));  chk("rd_c63", fb_rd, 1'b0);
      at(ln(0, 64));  chk("rd_c64", fb_rd, 1'b1);
                      chk("addr_c64", fb_addr, 16'h0000);
      at(ln(0, 65));  chk("addr_c65", fb_addr, 16'h0000);
      at(ln(0, 66));  chk("addr_c66", fb_addr, 16'h0001);
                      chk("border_c63", {red, green, blue}, 24'hFF0000);
      at(ln(0, 67));  chk("addr_c67", fb_addr, 16'h0001);
                      chk("win_c64", {red, green, blue}, 24'h000000);
                      chk("blank_c64", blank, 1'b0);
      at(ln(0, 577)); chk("win_c574", {red, green, blue}, 24'hFFFFFF);
      at(ln(0, 579)); chk("border_c576", {red, green, blue}, 24'hFF0000);
      at(ln(0, 600)); chk("rd_c600", fb_rd, 1'b0);
                      chk("addr_hold", fb_addr, 16'h00FF);
      at(ln(0, 642)); chk("border_c639", {red, green, blue}, 24'hFF0000);
                      chk("blank_c639", blank, 1'b0);
      at(ln(0, 643)); chk("blank_c640", blank, 1'b1);
                      chk("rgb_c640", {red, green, blue}, 24'h000000);

      at(ln(0, 658)); chk("hs_658", hsync, 1'b1);
      at(ln(0, 659)); chk("hs_659", hsync, 1'b0);
      at(ln(0, 754)); chk("hs_754", hsync, 1'b0);
      at(ln(0, 755)); chk("hs_755", hsync, 1'b1);

      at(ln(2, 66));  chk("addr_l2c66", fb_addr, 16'h0101);
      at(ln(2, 69));  chk("data_l2c66", {red, green, blue}, 24'h000055);
      at(ln(7, 575)); chk("rd_l7c575", fb_rd, 1'b1);
                      chk("addr_l7c575", fb_addr, 16'h03FF);
      at(ln(7, 578)); chk("data_l7c575", {red, green, blue}, 24'hFFFFFF);
      at(ln(8, 103)); chk("vblank", blank, 1'b1);
                      chk("vblank_rgb", {red, green, blue}, 24'h000000);

      at(ln(10, 2));  chk("vs_pre", vsync, 1'b1);
      at(ln(10, 3));  chk("vs_first", vsync, 1'b0);
      at(ln(12, 2));  chk("vs_last", vsync, 1'b0);
      at(ln(12, 3));  chk("vs_post", vsync, 1'b1);

      at(ln(15, 0) - 1); chk("fs2_pre", frame_start, 1'b0);
      at(ln(15, 0));     chk("fs2", frame_start, 1'b1);
      at(ln(15, 1));     chk("fs2_post", frame_start, 1'b0);

      // Line 5 of the second frame, stage-0 hcount 700: hsync output mid-pulse.
      at(ln(20, 700)); chk("mid_hs_low", hsync, 1'b0);
      reset_n = 1'b0;
      #1;
      chk("mid_hsync", hsync, 1'b1);
      chk("mid_vsync", vsync, 1'b1);
      chk("mid_blank", blank, 1'b1);
      chk("mid_rgb", {red, green, blue}, 24'h000000);
      chk("mid_fb_rd", fb_rd, 1'b0);
      chk("mid_fb_addr", fb_addr, 16'h0000);
      chk("mid_fs", frame_start, 1'b0);

      repeat (2) @(negedge clk_vga);
      reset_n = 1'b1;
      #1;
      chk("rel_fs_pre", frame_start, 1'b0);
      at(1);           chk("rel_fs", frame_start, 1'b1);
      at(ln(0, 658));  chk("rel_hs_658", hsync, 1'b1);
      at(ln(0, 659));  chk("rel_hs_659", hsync, 1'b0);
      at(ln(10, 3));   chk("rel_vs", vsync, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
